sha256_msg_sched_stream: RTL

//  Sequential SHA-256 message-schedule generator. Accepts one 512-bit padded block
//  and streams the schedule words W[0..ROUNDS-1], WPC words per beat, over a

---
 rtl/sha256_msg_sched_stream_if.sv | 25 ++
 rtl/sha256_msg_sched_stream.sv | 107 ++++++++++
 2 files changed

// File: rtl/sha256_msg_sched_stream_if.sv
// Block-in / schedule-word-out handshake bundle for the SHA-256 message scheduler.
// WPC sets the output beat width; it must match the scheduler instance it connects to.
interface sha256_msg_sched_stream_if #(
   parameter int WPC = 1
);
   logic                 blk_valid;
   logic                 blk_ready;
   logic [511:0]         blk_data;
   logic                 w_valid;
   logic                 w_ready;
   logic [32*WPC-1:0]    w_data;
   logic [6:0]           w_index;
   logic                 w_last;
   logic                 busy;

   modport slave (
      input  blk_valid, blk_data, w_ready,
      output blk_ready, w_valid, w_data, w_index, w_last, busy
   );

   modport master (
      output blk_valid, blk_data, w_ready,
      input  blk_ready, w_valid, w_data, w_index, w_last, busy
   );
endinterface

// File: rtl/sha256_msg_sched_stream.sv
// SHA-256 message schedule streamer: takes one padded 512-bit block and emits
// W[0..ROUNDS-1], WPC words per beat, from a 16-word sliding window.
module sha256_msg_sched_stream #(
   parameter int ROUNDS = 64,
   parameter int WPC    = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   sha256_msg_sched_stream_if.slave     bus
);

   generate
      if (!(WPC == 1 || WPC == 2 || WPC == 4) || ROUNDS < 16 || ROUNDS > 64 ||
          (ROUNDS % WPC) != 0) begin : g_bad_param
         $error("sha256_msg_sched_stream: illegal WPC/ROUNDS combination");
      end
   endgenerate

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              r_state, w_state_nxt;
   logic [15:0][31:0]   r_win;
   logic [15:0][31:0]   w_win_load;
   logic [15:0][31:0]   w_win_shift;
   logic [6:0]          r_t;
   logic [32*WPC-1:0]   w_new;
   logic                w_last_beat;
   logic                w_blk_ready;
   logic                w_xfer;
   logic                w_load;

   function automatic logic [31:0] f_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] f_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // Words of one beat are chained: for WPC=4 the third and fourth new words
   // take their W[n-2] term from the first and second new words.
   function automatic logic [32*WPC-1:0] f_expand(input logic [15:0][31:0] win);
      logic [16+WPC-1:0][31:0] ext;
      ext        = '0;
      ext[15:0]  = win;
      for (int j = 0; j < WPC; j++)
         ext[16+j] = f_s1(ext[14+j]) + ext[9+j] + f_s0(ext[1+j]) + ext[j];
      return ext[16+WPC-1:16];
   endfunction

   always_comb begin
      for (int i = 0; i < 16; i++)
         w_win_load[i] = bus.blk_data[511-32*i -: 32];
   end

   // Past t+16 >= ROUNDS nothing appended is ever presented, so feed zeros.
   always_comb begin
      w_new = '0;
      if (({1'b0, r_t} + 8'd16) < 8'(ROUNDS))
         w_new = f_expand(r_win);
   end

   assign w_win_shift = {w_new, r_win[15:WPC]};

   assign w_last_beat = (r_state == S_RUN) && ((r_t + 7'(WPC)) == 7'(ROUNDS));
   assign w_xfer      = (r_state == S_RUN) && bus.w_ready;
   assign w_blk_ready = (r_state == S_IDLE) || (w_xfer && w_last_beat);
   assign w_load      = bus.blk_valid && w_blk_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_load) w_state_nxt = S_RUN;
         S_RUN:  if (w_xfer && w_last_beat) w_state_nxt = w_load ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.blk_ready = w_blk_ready;
      bus.w_valid   = (r_state == S_RUN);
      bus.busy      = (r_state == S_RUN);
      bus.w_last    = w_last_beat;
      bus.w_index   = r_t;
      bus.w_data    = r_win[WPC-1:0];
   end

   // A load on the final beat wins over the shift: back-to-back blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win <= '0;
         r_t   <= '0;
      end else if (w_load) begin
         r_win <= w_win_load;
         r_t   <= '0;
      end else if (w_xfer) begin
         r_win <= w_win_shift;
         r_t   <= r_t + 7'(WPC);
      end
   end

endmodule
